cla_pipe_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.

---
 rtl/cla_pipe_addsub.sv | 123 ++++++++++++
 tb/tb_cla_pipe_addsub.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-wide lookahead slice per stage,
// carry and pending operand slices registered stage to stage, valid/ready handshake.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTG = WIDTH / BLOCK;

  logic adv;

  // Returns {carry out, slice sum}; the carry chain unrolls into flat G/P lookahead terms.
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             c0);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int IW = WIDTH - k * BLOCK;

    logic [IW-1:0]          a_in;
    logic [IW-1:0]          b_in;
    logic                   c_in;
    logic                   v_in;
    logic                   v_q;
    logic [BLOCK:0]         r;
    logic [(k+1)*BLOCK-1:0] s_d;
    logic [(k+1)*BLOCK-1:0] s_q;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign v_in = in_valid;
      assign s_d  = r[BLOCK-1:0];
    end else begin : g_body
      // Only the not-yet-added upper operand slices travel forward; low slice is always next.
      assign a_in = g_stg[k-1].g_fwd.a_q;
      assign b_in = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].g_fwd.c_q;
      assign v_in = g_stg[k-1].v_q;
      assign s_d  = {r[BLOCK-1:0], g_stg[k-1].s_q};
    end

    assign r = cla_slice(a_in[BLOCK-1:0], b_in[BLOCK-1:0], c_in);

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        v_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        s_q <= s_d;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      logic [IW-BLOCK-1:0] a_q;
      logic [IW-BLOCK-1:0] b_q;
      logic                c_q;

      always_ff @(posedge clock) begin
        if (adv) begin
          a_q <= a_in[IW-1:BLOCK];
          b_q <= b_in[IW-1:BLOCK];
          c_q <= r[BLOCK];
        end
      end
    end else begin : g_tail
      logic cout_q;
      logic ovf_q;
      logic zero_q;

      // Carry into the MSB is recovered as a^b^sum at that bit of the last slice.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv) begin
          cout_q <= r[BLOCK];
          ovf_q  <= r[BLOCK] ^ (a_in[IW-1] ^ b_in[IW-1] ^ r[BLOCK-1]);
          zero_q <= ~|s_d;
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_q;
  assign sum       = g_stg[NSTG-1].s_q;
  assign cout      = g_stg[NSTG-1].g_tail.cout_q;
  assign ovf       = g_stg[NSTG-1].g_tail.ovf_q;
  assign zero      = g_stg[NSTG-1].g_tail.zero_q;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub (WIDTH=32, BLOCK=8): directed vectors plus a short
// randomised stream against an arithmetic reference.
module tb_cla_pipe_addsub;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    res_t        r;
  } vec_t;

  res_t exp_q[$];
  vec_t vt[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   pops = 0;
  int   waits = 0;
  bit   rnd_bp = 1'b0;
  res_t mon_e;

  cla_pipe_addsub #(.WIDTH(32), .BLOCK(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                               input logic vc, input logic [31:0] es, input logic eco,
                               input logic eov, input logic ez);
    vec_t v;
    v.a = va; v.b = vb; v.sub = vs; v.cin = vc;
    v.r.s = es; v.r.co = eco; v.r.ov = eov; v.r.z = ez;
    return v;
  endfunction

  function automatic res_t ref_model(input logic [31:0] va, input logic [31:0] vb,
                                     input logic vs, input logic vc);
    logic [31:0] bb;
    logic [32:0] t;
    res_t r;
    bb   = vs ? ~vb : vb;
    t    = {1'b0, va} + {1'b0, bb} + {32'b0, (vs | vc)};
    r.s  = t[31:0];
    r.co = t[32];
    r.ov = (va[31] == bb[31]) && (t[31] != va[31]);
    r.z  = (t[31:0] == 32'h0);
    return r;
  endfunction

  // Monitor: compare whenever a result transfers at the coming edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got sum %h, expected no output", sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", sum, mon_e.s);
        chk("cout", {31'b0, cout}, {31'b0, mon_e.co});
        chk("ovf", {31'b0, ovf}, {31'b0, mon_e.ov});
        chk("zero", {31'b0, zero}, {31'b0, mon_e.z});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input vec_t v);
    int n;
    bit acc;
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
    end else begin
      exp_q.push_back(v.r);
      waits += n - 1;
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int p0;
    vec_t rv;

    vt.push_back(mkv(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    vt.push_back(mkv(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1));
    vt.push_back(mkv(32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0));
    vt.push_back(mkv(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1));
    vt.push_back(mkv(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0));
    vt.push_back(mkv(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1));
    vt.push_back(mkv(32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0));
    vt.push_back(mkv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0));

    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_sum", sum, 32'h0);
    chk("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
    tick();

    // Latency from accept to out_valid on an empty pipe
    send(vt[0]);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", lat, 32'd4);
    tick();
    drain();

    // Back-to-back at full throughput
    waits = 0;
    pop_cyc.delete();
    for (int i = 1; i <= 6; i++) send(vt[i]);
    in_valid = 1'b0;
    drain();
    chk("b2b_stalls", waits, 32'd0);
    chk("b2b_count", pop_cyc.size(), 32'd6);
    if (pop_cyc.size() == 6)
      for (int i = 1; i < 6; i++) chk("b2b_gap", pop_cyc[i] - pop_cyc[i-1], 32'd1);

    // Backpressure with the pipe full
    out_ready = 1'b0;
    for (int i = 7; i <= 10; i++) send(vt[i]);
    in_valid = 1'b0;
    chk("bp_queued", exp_q.size(), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_sum_held", sum, vt[7].r.s);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    p0 = pops;
    drain();
    chk("bp_results", pops - p0, 32'd4);

    // Reset with three ops in flight
    send(vt[11]);
    send(vt[0]);
    send(vt[1]);
    reset_n = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    p0 = pops;
    @(negedge clock);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (8) tick();
    chk("midrst_no_stale", pops - p0, 32'd0);
    send(vt[3]);
    drain();

    // Randomised stream with random gaps and backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      rv.a   = $urandom;
      rv.b   = ($urandom_range(0, 7) == 0) ? rv.a : $urandom;
      rv.sub = 1'($urandom_range(0, 1));
      rv.cin = 1'($urandom_range(0, 1));
      rv.r   = ref_model(rv.a, rv.b, rv.sub, rv.cin);
      send(rv);
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    repeat (3) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
